fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Produces the IF/ID register (`if_id_instruc`, `if_id_nextpc`) consumed by decode.
- Accepts decode's redirect controls (`id_if_*`) and execute's stall.
- Drives the instruction-memory request port and waits on a ready handshake.
- Branch/jump semantics: one delay slot; the instruction after a taken branch always executes.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'h0000_0080, target when `id_if_selpctype`=2'b11.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ex_if_stall  in  1  freeze PC and IF/ID.
- id_if_selpcsource  in  1  1 = take redirect target this cycle.
- id_if_selpctype  in  2  00 pcimd2ext (branch), 01 rega (jr), 10 pcindex (j), 11 EXC_VECTOR.
- id_if_pcimd2ext  in  32  branch target.
- id_if_rega  in  32  register jump target.
- id_if_pcindex  in  32  absolute jump target.
- mc_if_data  in  32  instruction word from memory.
- mc_if_ready  in  1  `mc_if_data` valid for `if_mc_addr` this cycle.
- if_mc_en  out  1  fetch request.
- if_mc_addr  out  32  fetch address; equals internal pc.
- if_id_instruc  out  32  IF/ID instruction (registered).
- if_id_nextpc  out  32  IF/ID address of fetched instruction + 4 (registered).

Behaviour:
- Reset (reset=0, immediate, asynchronous):
  - pc=RESET_PC; if_id_instruc=32'h0 (NOP); if_id_nextpc=0.
  - if_mc_en=0; redirect_pending=0; state=BOOT.
- FSM states: BOOT, RUN, WAIT.
  - BOOT: if_mc_en=0; IF/ID holds NOP; next state RUN unconditionally. This guarantees no request in the first edge after reset release.
  - RUN/WAIT: if_mc_en = ~ex_if_stall. State is RUN after an accepted fetch and WAIT after a cycle with mc_if_ready=0. The only difference between RUN and WAIT is observability: the test bench checks WAIT for bubble counting.
- Priority per rising edge (RUN/WAIT): stall > fetch-accept > bubble.
  - ex_if_stall=1: pc, IF/ID, redirect_pending and state all hold. mc_if_data is ignored even if mc_if_ready=1. id_if_selpcsource is ignored; the branch stays in IF/ID and re-asserts it after the stall.
  - Stall=0 and mc_if_ready=1 (accept):
    - if_id_instruc<=mc_if_data; if_id_nextpc<=pc+4.
    - pc <= redirect_pending ? redirect_pc : (id_if_selpcsource ? target : pc+4).
    - redirect_pending<=0; state<=RUN.
  - Stall=0 and mc_if_ready=0 (bubble):
    - if_id_instruc<=NOP; if_id_nextpc holds; pc holds; state<=WAIT.
    - If id_if_selpcsource=1 and redirect_pending=0: redirect_pc<=target and redirect_pending<=1. The branch leaves IF/ID, so its redirect must be remembered and applied after the delay slot is accepted.
- Target mux:
  - Selected by id_if_selpctype; 11 selects EXC_VECTOR.
  - Bits [1:0] are forced to 2'b00 for all targets (alignment). Unaligned jr is silently truncated.
- Arithmetic: pc+4 is 32-bit modulo, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- redirect_pending=1 implies IF/ID holds NOP, so id_if_selpcsource cannot legally assert. If it does, the pending target wins.
- if_mc_addr = pc combinationally, valid even when if_mc_en=0.
- Latency: from request with mc_if_ready=1 to instruction visible at if_id_instruc is 1 cycle. Each not-ready cycle adds one NOP bubble.
- Reset asserted mid-wait or mid-pending discards all state. The memory side must tolerate an abandoned request.

Decomposition:
- Shared pipeline package:
  - selpctype encodings (PCT_BRANCH=2'b00, PCT_REG=2'b01, PCT_INDEX=2'b10, PCT_EXC=2'b11).
  - NOP word 32'h0.
  - FSM state encodings (BOOT/RUN/WAIT).
- One natural sub-module, `pc_target_mux`: combinational 4:1 target select with alignment masking. Lets decode-side tests reuse it.
- FSM, pc, redirect_pc/redirect_pending and the IF/ID registers stay in `fetch_stage`.

Test Plan:
- Reset release, mc_if_ready=1, memory returns addr-tagged words:
  - Cycle after BOOT: if_mc_addr=0.
  - Then if_id_instruc = word@0, word@4, word@8 on consecutive cycles.
  - if_id_nextpc = 4, 8, 12.
- Branch in IF/ID with selpcsource=1, selpctype=00, pcimd2ext=32'h100:
  - Delay slot word@(branch+4) is captured.
  - Next if_mc_addr=32'h100.
- Same branch with mc_if_ready=0 for 2 cycles:
  - Two NOPs are emitted and redirect_pending=1.
  - On ready: delay slot captured, then if_mc_addr=32'h100.
- ex_if_stall=1 for 3 cycles while mc_if_ready=1 and a jump sits in IF/ID:
  - if_mc_en=0; pc, if_id_instruc and if_id_nextpc unchanged.
  - After stall release, jump to pcindex=32'h0040_0000 taken.
- jr with id_if_rega=32'h0000_0207: redirect lands at if_mc_addr=32'h0000_0204.
- Wrap-around and exception:
  - pc=32'hFFFF_FFFC accepted → next pc=0, if_id_nextpc=0.
  - selpctype=11 → if_mc_addr=EXC_VECTOR (32'h80).
  - Async reset mid-WAIT → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions: PC-select encodings, NOP word, fetch FSM states
// and the IF/ID register layout.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        PCT_BRANCH = 2'b00,
        PCT_REG    = 2'b01,
        PCT_INDEX  = 2'b10,
        PCT_EXC    = 2'b11
    } pctype_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    typedef struct packed {
        logic [31:0] instruc;
        logic [31:0] nextpc;
    } if_id_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_target_mux.sv
// Combinational redirect-target select; result is always word aligned.
// Zero latency, no flow control.
module pc_target_mux
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic [1:0]  i_selpctype,
    input  logic [31:0] i_pcimd2ext,
    input  logic [31:0] i_rega,
    input  logic [31:0] i_pcindex,
    output logic [31:0] o_target
);

    pctype_e     w_sel;
    logic [31:0] w_raw;

    assign w_sel = pctype_e'(i_selpctype);

    always_comb begin
        w_raw = i_pcimd2ext;
        case (w_sel)
            PCT_BRANCH: w_raw = i_pcimd2ext;
            PCT_REG:    w_raw = i_rega;
            PCT_INDEX:  w_raw = i_pcindex;
            PCT_EXC:    w_raw = EXC_VECTOR;
            default:    w_raw = i_pcimd2ext;
        endcase
    end

    // An unaligned jr target is truncated rather than trapped.
    assign o_target = align_word(w_raw);

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, delay-slot-aware redirect, IF/ID register.
// 1-cycle fetch latency; ex_if_stall freezes everything, mc_if_ready=0 inserts NOP bubbles.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ex_if_stall,
    input  logic        id_if_selpcsource,
    input  logic [1:0]  id_if_selpctype,
    input  logic [31:0] id_if_pcimd2ext,
    input  logic [31:0] id_if_rega,
    input  logic [31:0] id_if_pcindex,
    input  logic [31:0] mc_if_data,
    input  logic        mc_if_ready,
    output logic        if_mc_en,
    output logic [31:0] if_mc_addr,
    output logic [31:0] if_id_instruc,
    output logic [31:0] if_id_nextpc
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_redirect_pc;
    logic        r_redirect_pending;
    if_id_t      r_if_id;

    logic [31:0] w_target;
    logic [31:0] w_pc_inc;
    logic [31:0] w_pc_nxt;
    logic        w_fetch_en;
    logic        w_accept;
    logic        w_bubble;

    pc_target_mux #(
        .EXC_VECTOR (EXC_VECTOR)
    ) u_pc_target_mux (
        .i_selpctype (id_if_selpctype),
        .i_pcimd2ext (id_if_pcimd2ext),
        .i_rega      (id_if_rega),
        .i_pcindex   (id_if_pcindex),
        .o_target    (w_target)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN, ST_WAIT: begin
                if (!ex_if_stall) begin
                    w_state_nxt = mc_if_ready ? ST_RUN : ST_WAIT;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    // BOOT keeps the request low for the first edge after reset release.
    always_comb begin
        w_fetch_en = 1'b0;
        w_accept   = 1'b0;
        w_bubble   = 1'b0;
        case (r_state)
            ST_RUN, ST_WAIT: begin
                w_fetch_en = ~ex_if_stall;
                w_accept   = ~ex_if_stall & mc_if_ready;
                w_bubble   = ~ex_if_stall & ~mc_if_ready;
            end
            default: begin
                w_fetch_en = 1'b0;
                w_accept   = 1'b0;
                w_bubble   = 1'b0;
            end
        endcase
    end

    assign w_pc_inc = r_pc + PC_STEP;

    // A remembered redirect outranks a (never legal) fresh one.
    always_comb begin
        w_pc_nxt = w_pc_inc;
        if (r_redirect_pending) begin
            w_pc_nxt = r_redirect_pc;
        end else if (id_if_selpcsource) begin
            w_pc_nxt = w_target;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc               <= RESET_PC;
            r_if_id.instruc    <= NOP_WORD;
            r_if_id.nextpc     <= 32'h0;
            r_redirect_pc      <= 32'h0;
            r_redirect_pending <= 1'b0;
        end else if (w_accept) begin
            r_pc               <= w_pc_nxt;
            r_if_id.instruc    <= mc_if_data;
            r_if_id.nextpc     <= w_pc_inc;
            r_redirect_pending <= 1'b0;
        end else if (w_bubble) begin
            r_if_id.instruc <= NOP_WORD;
            // The branch drops out of IF/ID with the bubble, so its target is kept until the delay slot lands.
            if (id_if_selpcsource && !r_redirect_pending) begin
                r_redirect_pc      <= w_target;
                r_redirect_pending <= 1'b1;
            end
        end
    end

    assign if_mc_en      = w_fetch_en;
    assign if_mc_addr    = r_pc;
    assign if_id_instruc = r_if_id.instruc;
    assign if_id_nextpc  = r_if_id.nextpc;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized and directed bench for fetch_stage against a transaction-level model.
module tb_fetch_stage;

    logic        clock;
    logic        reset;
    logic        ex_if_stall;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_rega;
    logic [31:0] id_if_pcindex;
    logic [31:0] mc_if_data;
    logic        mc_if_ready;
    logic        if_mc_en;
    logic [31:0] if_mc_addr;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: the architectural view of the fetch stage.
    bit          m_booted;
    bit          m_pend;
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    logic [31:0] m_instr;
    logic [31:0] m_nextpc;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .EXC_VECTOR (32'h0000_0080)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .ex_if_stall       (ex_if_stall),
        .id_if_selpcsource (id_if_selpcsource),
        .id_if_selpctype   (id_if_selpctype),
        .id_if_pcimd2ext   (id_if_pcimd2ext),
        .id_if_rega        (id_if_rega),
        .id_if_pcindex     (id_if_pcindex),
        .mc_if_data        (mc_if_data),
        .mc_if_ready       (mc_if_ready),
        .if_mc_en          (if_mc_en),
        .if_mc_addr        (if_mc_addr),
        .if_id_instruc     (if_id_instruc),
        .if_id_nextpc      (if_id_nextpc)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory returns an address-tagged word for whatever address is presented.
    assign mc_if_data = word_at(if_mc_addr);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_target(input logic [1:0] sel);
        logic [31:0] t;
        case (sel)
            2'd0:    t = id_if_pcimd2ext;
            2'd1:    t = id_if_rega;
            2'd2:    t = id_if_pcindex;
            default: t = 32'h0000_0080;
        endcase
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic model_reset();
        m_booted  = 1'b0;
        m_pend    = 1'b0;
        m_pc      = 32'h0;
        m_pend_pc = 32'h0;
        m_instr   = 32'h0;
        m_nextpc  = 32'h0;
    endtask

    // Called at a falling edge; applies inputs for one cycle and checks the result.
    task automatic step(input bit st, input bit rdy, input bit src, input logic [1:0] sel);
        logic [31:0] tgt;
        ex_if_stall       = st;
        mc_if_ready       = rdy;
        id_if_selpcsource = src;
        id_if_selpctype   = sel;
        #1;
        check("mc_en", {31'b0, if_mc_en}, {31'b0, (m_booted && !st)});
        tgt = ref_target(sel);
        @(posedge clock);
        if (!m_booted) begin
            m_booted = 1'b1;
        end else if (!st) begin
            if (rdy) begin
                m_instr  = word_at(m_pc);
                m_nextpc = m_pc + 32'd4;
                if (m_pend)   m_pc = m_pend_pc;
                else if (src) m_pc = tgt;
                else          m_pc = m_pc + 32'd4;
                m_pend = 1'b0;
            end else begin
                m_instr = 32'h0;
                if (src && !m_pend) begin
                    m_pend    = 1'b1;
                    m_pend_pc = tgt;
                end
            end
        end
        @(negedge clock);
        check("addr", if_mc_addr, m_pc);
        check("instruc", if_id_instruc, m_instr);
        check("nextpc", if_id_nextpc, m_nextpc);
    endtask

    // Called at a falling edge; asserts reset between clock edges.
    task automatic async_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("rst_addr", if_mc_addr, 32'h0);
        check("rst_instruc", if_id_instruc, 32'h0);
        check("rst_nextpc", if_id_nextpc, 32'h0);
        check("rst_en", {31'b0, if_mc_en}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset             = 1'b0;
        ex_if_stall       = 1'b0;
        id_if_selpcsource = 1'b0;
        id_if_selpctype   = 2'b00;
        id_if_pcimd2ext   = 32'h0;
        id_if_rega        = 32'h0;
        id_if_pcindex     = 32'h0;
        mc_if_ready       = 1'b0;
        model_reset();

        #3;
        check("por_addr", if_mc_addr, 32'h0);
        check("por_instruc", if_id_instruc, 32'h0);
        check("por_nextpc", if_id_nextpc, 32'h0);
        check("por_en", {31'b0, if_mc_en}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        // Sequential fetch after boot
        step(0, 1, 0, 2'd0);
        check("boot_addr", if_mc_addr, 32'h0);
        step(0, 1, 0, 2'd0);
        check("seq_i0", if_id_instruc, word_at(32'h0));
        check("seq_n0", if_id_nextpc, 32'd4);
        step(0, 1, 0, 2'd0);
        check("seq_i1", if_id_instruc, word_at(32'h4));
        check("seq_n1", if_id_nextpc, 32'd8);
        step(0, 1, 0, 2'd0);
        check("seq_i2", if_id_instruc, word_at(32'h8));
        check("seq_n2", if_id_nextpc, 32'd12);

        // Taken branch with ready memory: delay slot then target
        id_if_pcimd2ext = 32'h0000_0100;
        step(0, 1, 1, 2'd0);
        check("br_slot", if_id_instruc, word_at(32'hC));
        check("br_addr", if_mc_addr, 32'h100);

        // Taken branch across two not-ready cycles
        step(0, 1, 0, 2'd0);
        step(0, 0, 1, 2'd0);
        check("brw_nop1", if_id_instruc, 32'h0);
        step(0, 0, 0, 2'd0);
        check("brw_nop2", if_id_instruc, 32'h0);
        check("brw_hold", if_mc_addr, 32'h104);
        step(0, 1, 0, 2'd0);
        check("brw_slot", if_id_instruc, word_at(32'h104));
        check("brw_addr", if_mc_addr, 32'h100);

        // Jump frozen by a 3-cycle stall, then taken
        step(0, 1, 0, 2'd0);
        id_if_pcindex = 32'h0040_0000;
        repeat (3) begin
            step(1, 1, 1, 2'd2);
            check("stl_en", {31'b0, if_mc_en}, 32'h0);
            check("stl_addr", if_mc_addr, 32'h104);
            check("stl_instr", if_id_instruc, word_at(32'h100));
            check("stl_npc", if_id_nextpc, 32'h104);
        end
        step(0, 1, 1, 2'd2);
        check("jmp_slot", if_id_instruc, word_at(32'h104));
        check("jmp_addr", if_mc_addr, 32'h0040_0000);

        // Unaligned register jump is truncated
        id_if_rega = 32'h0000_0207;
        step(0, 1, 1, 2'd1);
        check("jr_addr", if_mc_addr, 32'h0000_0204);

        // PC wrap-around
        id_if_pcindex = 32'hFFFF_FFFC;
        step(0, 1, 1, 2'd2);
        check("wrap_pre", if_mc_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 2'd0);
        check("wrap_addr", if_mc_addr, 32'h0);
        check("wrap_npc", if_id_nextpc, 32'h0);

        // Exception vector
        step(0, 1, 1, 2'd3);
        check("exc_addr", if_mc_addr, 32'h80);

        // Reset mid-WAIT with a pending redirect discards it
        id_if_pcimd2ext = 32'h0000_0300;
        step(0, 0, 1, 2'd0);
        async_reset();
        step(0, 1, 0, 2'd0);
        step(0, 1, 0, 2'd0);
        check("rst_drop_addr", if_mc_addr, 32'h4);
        check("rst_drop_instr", if_id_instruc, word_at(32'h0));

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_if_pcimd2ext = $urandom;
            id_if_rega      = $urandom;
            id_if_pcindex   = $urandom;
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 4) == 0, 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
